// File: rtl/asmd_seq_multiplier_if.sv
// Start/ready handshake and operand/result bundle for the sequential multiplier.
// The master drives the request side; the multiplier is the slave.
interface asmd_seq_multiplier_if #(
    parameter int word_length = 4
);
    logic                     start;
    logic                     signed_mode;
    logic [word_length-1:0]   word0;
    logic [word_length-1:0]   word1;
    logic [2*word_length-1:0] product;
    logic                     ready;
    logic                     done;

    modport master (
        output start, signed_mode, word0, word1,
        input  product, ready, done
    );

    modport slave (
        input  start, signed_mode, word0, word1,
        output product, ready, done
    );
endinterface

// File: rtl/asmd_seq_multiplier.sv
// Parametrised shift-add multiplier with IDLE/RUN/FIX control.
// It multiplies magnitudes and restores the sign in FIX, so one datapath serves both modes.
module asmd_seq_multiplier #(
    parameter int word_length = 4
) (
    input  logic               clk,
    input  logic               reset,
    asmd_seq_multiplier_if.slave bus
);
    localparam int W  = word_length;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t         r_state;
    state_t         w_next;
    logic [2*W:0]   r_acc;
    logic [W-1:0]   r_mcand;
    logic [W-1:0]   r_mplier;
    logic [CW-1:0]  r_cnt;
    logic           r_neg;
    logic [2*W-1:0] r_product;
    logic           r_ready;
    logic           r_done;

    logic           w_load;
    logic           w_step;
    logic           w_fix;
    logic [W:0]     w_sum;
    logic [2*W:0]   w_acc_next;
    logic [W-1:0]   w_mag0;
    logic [W-1:0]   w_mag1;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // NOTE: a default first keeps these comb blocks from inferring latches on unlisted paths.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_RUN;
            S_RUN:   if (r_cnt == CW'(1)) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_load = 1'b0;
        w_step = 1'b0;
        w_fix  = 1'b0;
        case (r_state)
            S_IDLE:  w_load = bus.start;
            S_RUN:   w_step = 1'b1;
            S_FIX:   w_fix  = 1'b1;
            default: ;
        endcase
    end

    // The most negative operand negates to itself, which read unsigned is its true magnitude.
    assign w_mag0 = (bus.signed_mode && bus.word0[W-1]) ? (~bus.word0 + 1'b1) : bus.word0;
    assign w_mag1 = (bus.signed_mode && bus.word1[W-1]) ? (~bus.word1 + 1'b1) : bus.word1;

    // Bit 2W is zero after every shift; including it keeps the carry of the add in view.
    assign w_sum      = r_acc[2*W:W] + (r_mplier[0] ? {1'b0, r_mcand} : '0);
    assign w_acc_next = {w_sum, r_acc[W-1:0]} >> 1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            r_product <= '0;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_fix;
            if (w_load) begin
                r_neg    <= bus.signed_mode & (bus.word0[W-1] ^ bus.word1[W-1]);
                r_mcand  <= w_mag0;
                r_mplier <= w_mag1;
                r_acc    <= '0;
                r_cnt    <= CW'(W);
                r_ready  <= 1'b0;
            end
            if (w_step) begin
                r_acc    <= w_acc_next;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt - 1'b1;
            end
            if (w_fix) begin
                r_product <= r_neg ? (~r_acc[2*W-1:0] + 1'b1) : r_acc[2*W-1:0];
                r_ready   <= 1'b1;
            end
        end
    end

    assign bus.product = r_product;
    assign bus.ready   = r_ready;
    assign bus.done    = r_done;
endmodule

// File: tb/tb_asmd_seq_multiplier.sv
// Directed bench for the sequential multiplier at widths 4 and 8.
// Expected products are queued at launch and popped when done is seen.
module tb_asmd_seq_multiplier;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    asmd_seq_multiplier_if #(.word_length(4)) if4 ();
    asmd_seq_multiplier_if #(.word_length(8)) if8 ();

    asmd_seq_multiplier #(.word_length(4)) dut4 (.clk(clk), .reset(reset), .bus(if4.slave));
    asmd_seq_multiplier #(.word_length(8)) dut8 (.clk(clk), .reset(reset), .bus(if8.slave));

    int          n_vec = 0;
    int          n_bad = 0;
    logic [15:0] q[$];
    logic [15:0] last;
    logic        wide;

    function automatic logic cur_done();
        return wide ? if8.done : if4.done;
    endfunction

    function automatic logic cur_ready();
        return wide ? if8.ready : if4.ready;
    endfunction

    function automatic logic [15:0] cur_prod();
        return wide ? if8.product : {8'h00, if4.product};
    endfunction

    function automatic logic [15:0] model4(input logic [3:0] a, input logic [3:0] b, input logic sm);
        logic [7:0] ea;
        logic [7:0] eb;
        ea = sm ? {{4{a[3]}}, a} : {4'h0, a};
        eb = sm ? {{4{b[3]}}, b} : {4'h0, b};
        return {8'h00, 8'(ea * eb)};
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_start(input logic [7:0] a, input logic [7:0] b, input logic sm);
        if (wide) begin
            if8.word0 = a; if8.word1 = b; if8.signed_mode = sm; if8.start = 1'b1;
        end else begin
            if4.word0 = a[3:0]; if4.word1 = b[3:0]; if4.signed_mode = sm; if4.start = 1'b1;
        end
    endtask

    task automatic drop_start();
        if4.start = 1'b0;
        if8.start = 1'b0;
    endtask

    task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic sm,
                          input logic [15:0] exp);
        drive_start(a, b, sm);
        q.push_back(exp);
        @(posedge clk); #1;
        drop_start();
        check("busy_after_capture", {15'b0, cur_ready()}, 16'd0);
    endtask

    // Counts edges after the capture edge until done; n0 edges may already have elapsed.
    task automatic wait_result(input string tag, input int n0);
        int          n;
        logic [15:0] exp;
        n = n0;
        do begin
            @(posedge clk); #1;
            n++;
            if (cur_done() !== 1'b1 && n < 20) check({tag, "_hold"}, cur_prod(), last);
        end while (cur_done() !== 1'b1 && n < 20);
        check({tag, "_latency"}, 16'(n), wide ? 16'd9 : 16'd5);
        exp = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
        check({tag, "_product"}, cur_prod(), exp);
        check({tag, "_ready"}, {15'b0, cur_ready()}, 16'd1);
        last = exp;
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic sm, input logic [15:0] exp);
        launch(a, b, sm, exp);
        wait_result(tag, 0);
        @(posedge clk); #1;
        check({tag, "_done_clear"}, {15'b0, cur_done()}, 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        wide  = 1'b0;
        last  = 16'h0000;
        reset = 1'b1;
        if4.start = 1'b0; if4.signed_mode = 1'b0; if4.word0 = '0; if4.word1 = '0;
        if8.start = 1'b0; if8.signed_mode = 1'b0; if8.word0 = '0; if8.word1 = '0;

        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        check("rst_ready", {15'b0, if4.ready}, 16'd1);
        check("rst_done", {15'b0, if4.done}, 16'd0);
        check("rst_product", {8'h00, if4.product}, 16'h0000);
        check("rst_product8", if8.product, 16'h0000);

        run_op("u3x3",   8'h3, 8'h3, 1'b0, 16'h0009);
        run_op("u15x15", 8'hF, 8'hF, 1'b0, 16'h00E1);
        run_op("u0x9",   8'h0, 8'h9, 1'b0, 16'h0000);
        run_op("s-3x5",  8'hD, 8'h5, 1'b1, 16'h00F1);
        run_op("s-8x-8", 8'h8, 8'h8, 1'b1, 16'h0040);
        run_op("s-8x7",  8'h8, 8'h7, 1'b1, 16'h00C8);
        run_op("u8x8",   8'h8, 8'h8, 1'b0, 16'h0040);
        run_op("uDx5",   8'hD, 8'h5, 1'b0, 16'h0041);

        for (int i = 0; i < 6; i++) begin
            logic [3:0] ra;
            logic [3:0] rb;
            logic       rs;
            ra = 4'($urandom_range(15));
            rb = 4'($urandom_range(15));
            rs = 1'($urandom_range(1));
            run_op("rand", {4'h0, ra}, {4'h0, rb}, rs, model4(ra, rb, rs));
        end

        // Busy protection: a 7x7 request during RUN must be ignored.
        launch(8'h2, 8'h3, 1'b0, 16'h0006);
        @(posedge clk); #1;
        drive_start(8'h7, 8'h7, 1'b0);
        @(posedge clk); #1;
        drop_start();
        check("busy_hold_e2", {8'h00, if4.product}, last);
        wait_result("busy", 2);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("busy_single_done", {15'b0, if4.done}, 16'd0);
            check("busy_stays_idle", {15'b0, if4.ready}, 16'd1);
        end

        // Reset during RUN discards the operation without a done pulse.
        drive_start(8'h5, 8'h5, 1'b0);
        @(posedge clk); #1;
        drop_start();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        last  = 16'h0000;
        check("abort_product", {8'h00, if4.product}, 16'h0000);
        check("abort_ready", {15'b0, if4.ready}, 16'd1);
        check("abort_done", {15'b0, if4.done}, 16'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("abort_no_done", {15'b0, if4.done}, 16'd0);
        end
        run_op("after_abort", 8'h2, 8'h2, 1'b0, 16'h0004);

        // Back-to-back: second request issued in the done cycle.
        launch(8'h6, 8'h7, 1'b0, 16'h002A);
        wait_result("b2b_first", 0);
        launch(8'hE, 8'h3, 1'b1, 16'h00FA);
        check("b2b_done_clear", {15'b0, if4.done}, 16'd0);
        wait_result("b2b_second", 0);
        @(posedge clk); #1;
        check("b2b_done_end", {15'b0, if4.done}, 16'd0);

        wide = 1'b1;
        last = 16'h0000;
        run_op("w8_s-128x-128", 8'h80, 8'h80, 1'b1, 16'h4000);
        run_op("w8_u255x255",   8'hFF, 8'hFF, 1'b0, 16'hFE01);
        run_op("w8_s-1x127",    8'hFF, 8'h7F, 1'b1, 16'hFF81);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
